// File: rtl/axi_stream_remove_header.sv
// Strips a k-byte header (k = byte_remove_cnt+1) off each packet and realigns the payload.
// One register stage on the payload path; header and payload channels stall independently.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_remove,
  output logic                    ready_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
);

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD:0]    k_q, k_d;
  logic [DATA_WD-1:0]      res_dat_q, res_dat_d;
  logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
  logic                    out_vld_q, out_vld_d;
  logic [DATA_WD-1:0]      out_dat_q, out_dat_d;
  logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic                    hdr_vld_q, hdr_vld_d;
  logic [DATA_WD-1:0]      hdr_dat_q, hdr_dat_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

  logic [31:0]             k_bits, r_bytes, r_bits;
  logic [DATA_WD-1:0]      din_m;
  logic [DATA_BYTE_WD-1:0] keep_tail;
  logic                    in_hs, rm_hs, out_free;

  // r_* is the residual (non-header) part of a beat, in bytes and bits
  assign k_bits    = 32'(k_q) << 3;
  assign r_bytes   = 32'(DATA_BYTE_WD) - 32'(k_q);
  assign r_bits    = r_bytes << 3;
  assign keep_tail = keep_in << k_q;
  assign out_free  = !out_vld_q || ready_out;

  assign ready_remove = !rst && (state_q == IDLE);
  assign ready_in     = !rst && (((state_q == FIRST) && !hdr_vld_q) ||
                                 ((state_q == BODY) && out_free));
  assign in_hs        = valid_in && ready_in;
  assign rm_hs        = valid_remove && ready_remove;

  always_comb begin
    din_m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (keep_in[i]) din_m[i*8 +: 8] = data_in[i*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    res_dat_d  = res_dat_q;
    res_keep_d = res_keep_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    hdr_vld_d  = hdr_vld_q;
    hdr_dat_d  = hdr_dat_q;
    hdr_keep_d = hdr_keep_q;
    if (out_vld_q && ready_out) out_vld_d = 1'b0;
    if (hdr_vld_q && ready_header) hdr_vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rm_hs) begin
          k_d     = {1'b0, byte_remove_cnt} + {{BYTE_CNT_WD{1'b0}}, 1'b1};
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (in_hs) begin
          hdr_vld_d  = 1'b1;
          hdr_dat_d  = din_m >> r_bits;
          hdr_keep_d = {DATA_BYTE_WD{1'b1}} >> r_bytes;
          res_dat_d  = din_m << k_bits;
          res_keep_d = keep_tail;
          state_d    = BODY;
        end
      end
      BODY: begin
        if (in_hs) begin
          out_vld_d  = 1'b1;
          out_dat_d  = res_dat_q | (din_m >> r_bits);
          out_keep_d = res_keep_q | (keep_in >> r_bytes);
          out_last_d = last_in && (keep_tail == '0);
          res_dat_d  = din_m << k_bits;
          res_keep_d = keep_tail;
          // bytes left over after the header-sized slice need one more beat
          if (last_in) state_d = (keep_tail != '0) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_vld_d  = 1'b1;
          out_dat_d  = res_dat_q;
          out_keep_d = res_keep_q;
          out_last_d = 1'b1;
          res_dat_d  = '0;
          res_keep_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      res_dat_q  <= '0;
      res_keep_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      hdr_vld_q  <= 1'b0;
      hdr_dat_q  <= '0;
      hdr_keep_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      res_dat_q  <= res_dat_d;
      res_keep_q <= res_keep_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      hdr_vld_q  <= hdr_vld_d;
      hdr_dat_q  <= hdr_dat_d;
      hdr_keep_q <= hdr_keep_d;
    end
  end

  assign valid_out    = out_vld_q;
  assign data_out     = out_dat_q;
  assign keep_out     = out_keep_q;
  assign last_out     = out_last_q;
  assign valid_header = hdr_vld_q;
  assign data_header  = hdr_dat_q;
  assign keep_header  = hdr_keep_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed and model-checked stimulus for axi_stream_remove_header (32-bit bus).
module tb_axi_stream_remove_header;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, ready_in, last_in;
  logic [DW-1:0] data_in;
  logic [BW-1:0] keep_in;
  logic          valid_remove, ready_remove;
  logic [CW-1:0] byte_remove_cnt;
  logic          valid_out, ready_out, last_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          valid_header, ready_header;
  logic [DW-1:0] data_header;
  logic [BW-1:0] keep_header;

  axi_stream_remove_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_remove(valid_remove), .ready_remove(ready_remove), .byte_remove_cnt(byte_remove_cnt),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .valid_header(valid_header), .ready_header(ready_header), .data_header(data_header), .keep_header(keep_header)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [DW-1:0]    out_dat_q[$];
  logic [BW-1:0]    out_keep_q[$];
  logic             out_last_q[$];
  logic [DW+BW-1:0] hdr_q[$];
  logic [7:0]       got_bytes[$];
  logic [7:0]       exp_bytes[$];
  int               got_len[$];
  int               acc_len = 0;

  logic          st_v = 1'b0;
  logic [DW-1:0] st_dat;
  logic [BW-1:0] st_keep;
  logic          st_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] kmask(input logic [BW-1:0] k);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < BW; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // ready_out pattern: 0 = always ready, 1 = 1-0-0-1 repeating, 2 = random
  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        1:       ready_out = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       ready_out = ($urandom_range(0, 1) != 0);
        default: ready_out = 1'b1;
      endcase
    end
  end

  // output / header monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      st_v = 1'b0;
      acc_len = 0;
    end else begin
      if (st_v)
        check("out_stable", {valid_out, data_out, keep_out, last_out}, {1'b1, st_dat, st_keep, st_last});
      if (valid_out && ready_out) begin
        out_dat_q.push_back(data_out);
        out_keep_q.push_back(keep_out);
        out_last_q.push_back(last_out);
        check("out_zero_pad", data_out & ~kmask(keep_out), 64'd0);
        for (int i = BW - 1; i >= 0; i--) begin
          if (keep_out[i]) begin
            got_bytes.push_back(data_out[i*8 +: 8]);
            acc_len++;
          end
        end
        if (last_out) begin
          got_len.push_back(acc_len);
          acc_len = 0;
        end
      end
      if (valid_header && ready_header) hdr_q.push_back({data_header, keep_header});
      st_v = valid_out && !ready_out;
      st_dat = data_out;
      st_keep = keep_out;
      st_last = last_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_remove(input logic [CW-1:0] c);
    int n;
    n = 0;
    valid_remove = 1'b1;
    byte_remove_cnt = c;
    @(negedge clk);
    while (!ready_remove && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("remove_wait", 64'(n < 100), 64'd1);
    tick();
    valid_remove = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    int n;
    n = 0;
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    @(negedge clk);
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_wait", 64'(n < 100), 64'd1);
    tick();
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    logic [DW+BW:0] g;
    g = 'x;
    if (out_dat_q.size() != 0) g = {out_dat_q.pop_front(), out_keep_q.pop_front(), out_last_q.pop_front()};
    check(tag, g, {d, k, l});
  endtask

  task automatic expect_hdr(input string tag, input logic [DW-1:0] d, input logic [BW-1:0] k);
    logic [DW+BW-1:0] g;
    g = 'x;
    if (hdr_q.size() != 0) g = hdr_q.pop_front();
    check(tag, g, {d, k});
  endtask

  task automatic clear_all();
    out_dat_q.delete();
    out_keep_q.delete();
    out_last_q.delete();
    hdr_q.delete();
    got_bytes.delete();
    got_len.delete();
  endtask

  task automatic packet_abc(input logic [CW-1:0] c, input logic [BW-1:0] last_keep);
    send_remove(c);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    send_beat(32'hC1C2C3C4, last_keep, 1'b1);
    repeat (6) tick();
  endtask

  initial begin
    int hs;
    int bad;
    int exp_len[$];
    logic [DW+BW-1:0] exp_hdr[$];

    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_remove = 1'b0; byte_remove_cnt = '0;
    ready_header = 1'b1;
    repeat (3) tick();
    check("rst_out", {valid_out, last_out, data_out, keep_out}, 64'd0);
    check("rst_hdr", {valid_header, data_header, keep_header}, 64'd0);
    check("rst_rdy", {ready_in, ready_remove}, 64'd0);
    rst = 1'b0;
    tick();

    // k=2, ends exactly on a header-sized boundary: no flush beat
    packet_abc(2'd1, 4'b1100);
    expect_hdr("k2_hdr", 32'h0000A1A2, 4'b0011);
    expect_out("k2_out0", 32'hA3A4B1B2, 4'b1111, 1'b0);
    expect_out("k2_out1", 32'hB3B4C1C2, 4'b1111, 1'b1);
    check("k2_extra", out_dat_q.size(), 64'd0);

    // k=1, last beat has more bytes than k: flush beat
    packet_abc(2'd0, 4'b1110);
    expect_hdr("k1_hdr", 32'h000000A1, 4'b0001);
    expect_out("k1_out0", 32'hA2A3A4B1, 4'b1111, 1'b0);
    expect_out("k1_out1", 32'hB2B3B4C1, 4'b1111, 1'b0);
    expect_out("k1_flush", 32'hC2C30000, 4'b1100, 1'b1);
    check("k1_extra", out_dat_q.size(), 64'd0);

    // k=4, whole first beat is header, payload passes through
    packet_abc(2'd3, 4'b1100);
    expect_hdr("k4_hdr", 32'hA1A2A3A4, 4'b1111);
    expect_out("k4_out0", 32'hB1B2B3B4, 4'b1111, 1'b0);
    expect_out("k4_out1", 32'hC1C20000, 4'b1100, 1'b1);
    check("k4_extra", out_dat_q.size(), 64'd0);

    // payload backpressure 1-0-0-1 and header held while the next packet arrives
    ready_header = 1'b0;
    rdy_mode = 1;
    hs = cyc;
    send_remove(2'd1);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    send_beat(32'h99AABBCC, 4'b1111, 1'b1);
    send_remove(2'd0);
    repeat (3) begin
      @(negedge clk);
      check("hold_first_stall", {ready_in, valid_header, data_header, keep_header},
            {1'b0, 1'b1, 32'h00001122, 4'b0011});
      tick();
    end
    while ((cyc - hs) < 10) tick();
    ready_header = 1'b1;
    send_beat(32'hE1E2E3E4, 4'b1111, 1'b0);
    send_beat(32'hF1F2F3F4, 4'b1000, 1'b1);
    repeat (12) tick();
    rdy_mode = 0;
    repeat (4) tick();
    expect_hdr("bp_hdr0", 32'h00001122, 4'b0011);
    expect_hdr("bp_hdr1", 32'h000000E1, 4'b0001);
    expect_out("bp_out0", 32'h33445566, 4'b1111, 1'b0);
    expect_out("bp_out1", 32'h778899AA, 4'b1111, 1'b0);
    expect_out("bp_flush", 32'hBBCC0000, 4'b1100, 1'b1);
    expect_out("bp_vk", 32'hE2E3E4F1, 4'b1111, 1'b1);
    check("bp_extra", out_dat_q.size(), 64'd0);

    // reset in the middle of a 12-beat packet
    send_remove(2'd2);
    for (int i = 0; i < 5; i++) send_beat(32'h10203040 + 32'(i), 4'b1111, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_outs", {valid_out, valid_header, ready_in, ready_remove}, 64'd0);
    rst = 1'b0;
    clear_all();
    repeat (4) tick();
    check("mid_rst_quiet", out_dat_q.size(), 64'd0);
    check("mid_rst_idle", {ready_remove, ready_in}, 64'd2);
    packet_abc(2'd1, 4'b1100);
    expect_hdr("post_rst_hdr", 32'h0000A1A2, 4'b0011);
    expect_out("post_rst_out0", 32'hA3A4B1B2, 4'b1111, 1'b0);
    expect_out("post_rst_out1", 32'hB3B4C1C2, 4'b1111, 1'b1);
    check("post_rst_extra", out_dat_q.size(), 64'd0);

    // back-to-back random packets against a byte-level model
    clear_all();
    rdy_mode = 2;
    for (int p = 0; p < 10; p++) begin
      int c, k, nb, v, nbytes;
      logic [DW-1:0] d, hd;
      logic [BW-1:0] kp, hk;
      c = int'($urandom_range(0, 3));
      k = c + 1;
      nb = int'($urandom_range(10, 17));
      v = int'($urandom_range(1, 4));
      hd = '0;
      hk = '0;
      for (int j = 0; j < k; j++) hk[j] = 1'b1;
      send_remove(2'(c));
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        kp = 4'b1111;
        nbytes = 4;
        if (b == nb - 1) begin
          kp = '0;
          for (int j = 0; j < v; j++) kp[3-j] = 1'b1;
          nbytes = v;
        end
        for (int j = 0; j < nbytes; j++) begin
          if (b == 0 && j < k) hd = {hd[23:0], d[31-8*j -: 8]};
          else exp_bytes.push_back(d[31-8*j -: 8]);
        end
        send_beat(d, kp, b == nb - 1);
      end
      exp_hdr.push_back({hd, hk});
      exp_len.push_back((nb - 1) * 4 + v - k);
    end
    rdy_mode = 0;
    repeat (20) tick();
    check("rnd_nbytes", got_bytes.size(), exp_bytes.size());
    bad = 0;
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
      if (got_bytes[i] !== exp_bytes[i]) bad++;
    check("rnd_byte_errs", bad, 64'd0);
    check("rnd_last_count", got_len.size(), 64'd10);
    for (int p = 0; p < 10; p++) begin
      expect_hdr("rnd_hdr", exp_hdr[p][DW+BW-1:BW], exp_hdr[p][BW-1:0]);
      check("rnd_pkt_len", (p < got_len.size()) ? 64'(got_len[p]) : 64'hFFFF, 64'(exp_len[p]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_stream_remove_header.md
AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32: data bus width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8: bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD): width of byte_remove_cnt.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have valid_in/ready_in (in/out, 1), data_in (in, DATA_WD), keep_in (in, DATA_BYTE_WD), last_in (in, 1): input packet stream carrying header+payload.
REQ-007 SHALL have valid_remove/ready_remove (in/out, 1), byte_remove_cnt (in, BYTE_CNT_WD): per-packet strip request; header length k = byte_remove_cnt+1 bytes.
REQ-008 SHALL have valid_out/ready_out (out/in, 1), data_out (out, DATA_WD), keep_out (out, DATA_BYTE_WD), last_out (out, 1): realigned payload stream.
REQ-009 SHALL have valid_header/ready_header (out/in, 1), data_header (out, DATA_WD), keep_header (out, DATA_BYTE_WD): extracted header.

Function
REQ-010 SHALL order bytes MSB-first: byte 0 of a beat is data[DATA_WD-1 -: 8]; keep_in/keep_out MSB-aligned contiguous.
REQ-011 SHALL transfer on any channel only when valid and ready are both high at a rising edge.
REQ-012 SHALL implement states IDLE, FIRST, BODY, FLUSH.
REQ-013 IDLE: ready_remove=1, ready_in=0; on valid_remove handshake latch k, go FIRST.
REQ-014 FIRST: ready_in=1 only when header register empty; on handshake load data_header = first k bytes right-aligned (upper bytes zero), keep_header = low k bits set, valid_header=1; store remaining DATA_BYTE_WD-k bytes as residual; go BODY.
REQ-015 Input precondition: first beat keep all-ones and last_in=0 (packet >= 2 beats); behaviour otherwise undefined.
REQ-016 BODY: each input beat produces one output beat = {residual, top k bytes of current beat}; new residual = low DATA_BYTE_WD-k bytes of current beat.
REQ-017 Last input beat with v valid bytes: if v <= k, output beat has (DATA_BYTE_WD-k)+v bytes, last_out=1, go IDLE; else output beat full, go FLUSH.
REQ-018 FLUSH: ready_in=0; emit one beat with v-k bytes MSB-aligned, last_out=1; on handshake go IDLE.
REQ-019 k = DATA_BYTE_WD: residual empty; payload beats pass through unchanged after first beat, never FLUSH.
REQ-020 Payload output SHALL be a single register stage: ready_in in BODY = !valid_out || ready_out; first payload beat valid the cycle after the second input handshake.
REQ-021 Header register SHALL hold data until ready_header handshake, independent of payload channel; a new FIRST beat stalls while it is full.
REQ-022 Output data/keep/last SHALL be stable while valid_out=1 and ready_out=0; same for header channel.
REQ-023 valid_remove for the next packet SHALL only be accepted in IDLE; simultaneous last_in and valid_remove takes last_in first.
REQ-024 Unused bytes of data_out (keep bit 0) SHALL be zero.

Reset
REQ-025 On rst=1 at a rising edge: state IDLE, valid_out=0, valid_header=0, last_out=0, data_out/keep_out/data_header/keep_header=0, ready_in=0, ready_remove=0 while rst high.
REQ-026 Reset mid-packet SHALL discard residual and partial packet with no further output beats; next packet starts clean.

Verification
REQ-027 k=2 (cnt=1), beats A1A2A3A4/1111, B1B2B3B4/1111, C1C2C3C4/1100 last -> header 0000A1A2/0011; out A3A4B1B2/1111, B3B4C1C2/1111 last, no FLUSH.
REQ-028 k=1 (cnt=0), same beats but last keep 1110 -> header 000000A1/0001; out A2A3A4B1, B2B3B4C1 (1111), C2C3_0000/1100 last via FLUSH.
REQ-029 k=4 (cnt=3) -> header A1A2A3A4/1111; out B1B2B3B4/1111, C1C2_0000/1100 last.
REQ-030 ready_out toggling 1-0-0-1 mid-packet, ready_header=0 for 10 cycles -> no lost/duplicated bytes, outputs stable while stalled, next FIRST stalls until header taken.
REQ-031 rst asserted 1 cycle during BODY of 12-beat packet -> valid_out=0 next cycle, IDLE; following k=2 packet correct per REQ-027.
REQ-032 10 back-to-back random packets (10-17 beats, random cnt and last keep) vs reference model -> byte-exact payload and header match, last_out once per packet.
